// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds store-size codes, load funct3 codes, the FSM state encoding,
// the bus timeout limit and the alignment check used when an access is
// presented.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_SB   = 2'b01,
        MEM_SH   = 2'b10,
        MEM_SW   = 2'b11
    } mem_write_e;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    localparam int unsigned   TIMEOUT_LIMIT = 16;
    localparam int unsigned   CNT_W         = 4;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_LIMIT - 1);

    // Stores take their size from MemWrite; loads from funct3. Byte
    // accesses and unknown load codes never fault.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [1:0] mem_write,
                                           input logic [2:0] load_size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            case (mem_write)
                MEM_SH:  mis = addr_lo[0];
                MEM_SW:  mis = |addr_lo;
                default: mis = 1'b0;
            endcase
        end else begin
            case (load_size)
                LS_LH, LS_LHU: mis = addr_lo[0];
                LS_LW:         mis = |addr_lo;
                default:       mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-oriented data bus between the memory access unit and memory.
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be : request side (master drives)
//   bus_ready/bus_rdata                      : response side (slave drives)
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load data alignment and extension.
//   rdata     : raw 32-bit bus word
//   addr_lo   : byte offset within the word
//   load_size : load funct3
//   result    : shifted and sign/zero-extended load value
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_size,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (load_size)
            LS_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            LS_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            LS_LBU:  result = {24'h0, shifted[7:0]};
            LS_LHU:  result = {16'h0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a load/store in M into a single bus
// transaction, stalling the pipeline until it completes.
//   clk, rst        : clock, asynchronous active-low reset
//   MemWriteM       : store size (none/SB/SH/SW)
//   ResultSrcM      : 01 marks a load
//   LoadSizeM       : load funct3
//   ALUResultM      : byte address; WriteDataM: store data
//   StallM          : hold M and earlier stages
//   ReadDataM       : registered load result
//   MisalignM       : pulse, misaligned access dropped
//   BusErrM         : pulse, bus timed out
//   bus             : request/response bus (master side)
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    mem_access_unit_if.master bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        lsize_q, lsize_d;

    logic              is_store, is_access, misaligned;
    logic [3:0]        store_be;
    logic [31:0]       store_wdata;
    logic [31:0]       ext_data;

    // A load that also carries a store size is handled as a store.
    assign is_store   = (MemWriteM != MEM_NONE);
    assign is_access  = is_store || (ResultSrcM == RES_SRC_LOAD);
    assign misaligned = is_misaligned(is_store, MemWriteM, LoadSizeM, ALUResultM[1:0]);

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = WriteDataM;
        case (MemWriteM)
            MEM_SB: begin
                store_be    = 4'b0001 << ALUResultM[1:0];
                store_wdata = {4{WriteDataM[7:0]}};
            end
            MEM_SH: begin
                store_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                store_wdata = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .rdata     (bus.bus_rdata),
        .addr_lo   (off_q),
        .load_size (lsize_q),
        .result    (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        off_d       = off_q;
        lsize_d     = lsize_q;
        StallM      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_access) begin
                    if (misaligned) begin
                        misalign_d  = 1'b1;
                        read_data_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        StallM      = 1'b1;
                        cnt_d       = '0;
                        bus_we_d    = is_store;
                        bus_addr_d  = {ALUResultM[31:2], 2'b00};
                        bus_wdata_d = is_store ? store_wdata : '0;
                        bus_be_d    = is_store ? store_be : 4'b1111;
                        off_d       = ALUResultM[1:0];
                        lsize_d     = LoadSizeM;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                StallM = 1'b1;
                // bus_ready is checked first so a response on the last
                // allowed cycle still completes normally.
                if (bus.bus_ready) begin
                    if (!bus_we_q) begin
                        read_data_d = ext_data;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    bus_err_d   = 1'b1;
                    read_data_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            off_q       <= '0;
            lsize_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            off_q       <= off_d;
            lsize_q     <= lsize_d;
        end
    end

    assign ReadDataM     = read_data_q;
    assign MisalignM     = misalign_q;
    assign BusErrM       = bus_err_q;
    assign bus.bus_req   = (state_q == ST_ACCESS);
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_be    = bus_be_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 MemWriteM  input  2  store size: 00 none, 01 SB, 10 SH, 11 SW.
REQ-004 ResultSrcM  input  2  01 = load instruction in M stage; other values = not a load.
REQ-005 LoadSizeM  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 ALUResultM  input  32  effective byte address.
REQ-007 WriteDataM  input  32  store data (rs2).
REQ-008 StallM  output  1  hold the IE/DM register and all earlier stages this cycle.
REQ-009 ReadDataM  output  32  registered, extended load result.
REQ-010 MisalignM  output  1  one-cycle pulse: misaligned access dropped.
REQ-011 BusErrM  output  1  one-cycle pulse: bus timeout.
REQ-012 bus_req, bus_we  output  1 each  request valid; write when 1.
REQ-013 bus_addr  output  32  {ALUResultM[31:2],2'b00}.
REQ-014 bus_wdata  output  32  lane-replicated store data; bus_be  output  4  byte enables.
REQ-015 bus_ready  input  1; bus_rdata  input  32  read word, valid when bus_ready=1.

Function
REQ-016 States: IDLE, ACCESS, DONE; an access = load (ResultSrcM=01) or store (MemWriteM!=00); a load with MemWriteM!=00 is treated as a store.
REQ-017 IDLE, aligned access present: StallM=1 combinationally, next state ACCESS; no access: StallM=0, stay IDLE.
REQ-018 Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0; in IDLE: no bus request, MisalignM=1 next cycle, ReadDataM<=0, StallM=0, next state DONE.
REQ-019 ACCESS: bus_req=1, StallM=1, bus_addr/bus_we/bus_be/bus_wdata registered on IDLE->ACCESS and held stable until bus_ready.
REQ-020 ACCESS with bus_ready=1: load result captured into ReadDataM, next state DONE; earliest completion = 2 cycles after presentation.
REQ-021 DONE: StallM=0, bus_req=0, inputs ignored; next state IDLE unconditionally (instruction leaves M at end of DONE).
REQ-022 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111.
REQ-023 bus_wdata: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
REQ-024 Load extract: shift bus_rdata right by 8*addr[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unmodified; undefined funct3 -> zero-extended word.
REQ-025 Timeout: 4-bit counter cleared on ACCESS entry, incremented each ACCESS cycle without bus_ready; ACCESS duration reaching 16 cycles without bus_ready -> bus_req drops, BusErrM=1 one cycle, ReadDataM<=0, next state DONE.
REQ-026 bus_ready in the same cycle the counter reaches 15 wins over timeout.
REQ-027 bus_ready outside ACCESS is ignored.
REQ-028 ReadDataM holds value until next completed load; stores do not alter it.

Reset
REQ-029 rst=0 forces state IDLE, counter 0, ReadDataM=0, MisalignM=0, BusErrM=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0 immediately, independent of clk.
REQ-030 Reset during ACCESS aborts the transaction; bus_req falls asynchronously; no BusErrM pulse.
REQ-031 First access after rst deassertion is accepted on the first rising edge with rst=1.

Structure
REQ-032 Shared package: MemWrite size codes, LoadSize funct3 codes, state encoding, timeout limit (16).
REQ-033 One sub-module load_extend (combinational: rdata, addr[1:0], LoadSizeM -> 32-bit result) reusable by the writeback path.

Verification
REQ-034 LB addr 0x103, bus_rdata 0x80FF1234, ready on first ACCESS cycle -> bus_be=4'b1111, ReadDataM=0xFFFFFF80, StallM high 2 cycles.
REQ-035 SH addr 0x202, WriteDataM 0xAAAA5678 -> bus_we=1, bus_be=4'b1100, bus_wdata=0x56785678, bus_addr=0x200.
REQ-036 LW addr 0x101 -> no bus_req, MisalignM pulse, ReadDataM=0, StallM=0 in presentation cycle.
REQ-037 LHU addr 0x002, bus_ready held low 16 cycles -> BusErrM pulse, ReadDataM=0, state returns IDLE; ready on 16th cycle instead -> normal completion, no BusErrM.
REQ-038 rst=0 mid-ACCESS (cycle 3 of wait) -> bus_req=0 same cycle, outputs at reset values, next SW after release completes normally.
